fetch_unit: RTL and testbench



---
 rtl/rv32_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: machine width, major opcodes, the canonical NOP,
// the fetch FSM state type and a word-alignment helper.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush and occupancy count. Push into a full
// queue is honoured only when a pop happens in the same cycle.
module fetch_queue
    import rv32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

    // Entry storage: plain data, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush takes priority over push and pop.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC register, credit-limited request issue,
// in-order response buffering and redirect/flush handling.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [6:0]  dec_opcode
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);
    localparam logic [AW:0]   ONE        = (AW+1)'(1);

    fetch_state_t     r_state;
    logic [XLEN-1:0]  r_pc;
    logic [AW:0]      r_outstanding;
    logic [AW:0]      r_drop;

    logic [AW:0]      w_q_count;
    logic [AW:0]      w_pcf_count;
    logic [63:0]      w_q_head;
    logic [31:0]      w_pcf_head;
    logic [AW+1:0]    w_credit_used;
    logic [AW:0]      w_remaining;
    logic             w_req_fire;
    logic             w_resp_ok;
    logic             w_q_push;
    logic             w_q_pop;
    logic             w_q_nonempty;

    // Requests count against the same budget as buffered instructions so
    // every response is guaranteed a queue slot.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign imem_req_valid = !rst && (r_state == FETCH_RUN) && !redirect_valid
                            && (w_credit_used < CREDIT_MAX);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_ok   = imem_resp_valid && (r_outstanding != '0);
    assign w_remaining = r_outstanding - {{AW{1'b0}}, w_resp_ok};
    assign w_q_push    = imem_resp_valid && (r_state == FETCH_RUN) && !redirect_valid
                         && (r_drop == '0) && (w_pcf_count != '0);

    assign w_q_nonempty = (w_q_count != '0);
    assign dec_valid    = !rst && w_q_nonempty && !redirect_valid;
    assign w_q_pop      = dec_valid && dec_ready;
    assign dec_instr    = w_q_nonempty ? w_q_head[31:0]  : '0;
    assign dec_pc       = w_q_nonempty ? w_q_head[63:32] : '0;
    assign dec_opcode   = dec_instr[6:0];

    // Fetch control: PC, in-flight count, drop count and RUN/FLUSH state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH_RUN;
            r_pc          <= word_align(RESET_PC);
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + {{AW{1'b0}}, w_req_fire}
                                           - {{AW{1'b0}}, w_resp_ok};
            if (redirect_valid) begin
                r_pc    <= word_align(redirect_pc);
                r_drop  <= w_remaining;
                r_state <= (w_remaining != '0) ? FETCH_FLUSH : FETCH_RUN;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if ((r_state == FETCH_FLUSH) && w_resp_ok) begin
                    r_drop <= r_drop - ONE;
                    if (r_drop == ONE) begin
                        r_state <= FETCH_RUN;
                    end
                end
            end
        end
    end

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_q_push),
        .o_data  (w_pcf_head),
        .o_count (w_pcf_count)
    );

    fetch_queue #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_dec_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_q_push),
        .i_data  ({w_pcf_head, imem_resp_data}),
        .i_pop   (w_q_pop),
        .o_data  (w_q_head),
        .o_count (w_q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fixed-latency memory model, stream-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;
    import rv32_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_lat;
    bit          mem_stall;
    int          acc_cnt;
    int          cyc;
    int          due_q[$];
    logic [31:0] addr_q[$];

    logic [31:0] m_req_pc;
    logic [31:0] m_dec_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_opcode      (dec_opcode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: opcode cycles through the major opcodes, upper bits
    // carry an address-derived tag so stale or mispaired words are visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OP_LOAD;
            3'd1:    op = OP_STORE;
            3'd2:    op = OP_R;
            3'd3:    op = OP_BRANCH;
            3'd4:    op = OP_IMM;
            3'd5:    op = OP_JAL;
            3'd6:    op = OP_AUIPC;
            default: op = OP_LUI;
        endcase
        return {a[26:2] ^ 25'h0AB_CDE, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dec(input logic [31:0] pc, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dec_valid && dec_ready && dec_pc == pc) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_dec: pc %h not decoded within %0d cycles (seen=%0d, required 1)", pc, budget, seen);
        end
    endtask

    // Instruction memory: fixed latency, in-order, optional random ready.
    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        acc_cnt = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                due_q.delete();
                addr_q.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                due_q.push_back(cyc + mem_lat);
                addr_q.push_back(imem_req_addr);
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            cyc++;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(addr_q[0]);
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end
            imem_req_ready = mem_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Reference model: request addresses and decoded PCs each form a +4
    // sequence restarted by reset and by every redirect; each decoded word
    // must equal memory contents at its PC.
    initial begin
        logic [31:0] exp_i;
        m_req_pc = RESET_PC;
        m_dec_pc = RESET_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
                m_req_pc = RESET_PC;
                m_dec_pc = RESET_PC;
            end else if (redirect_valid) begin
                chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
                chk("redir_dec_valid", {31'b0, dec_valid}, 32'd0);
                m_req_pc = redirect_pc & ~32'h3;
                m_dec_pc = redirect_pc & ~32'h3;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_req_addr, m_req_pc);
                    m_req_pc = m_req_pc + 32'd4;
                end
                if (dec_valid && dec_ready) begin
                    exp_i = mem_word(m_dec_pc);
                    chk("dec_pc", dec_pc, m_dec_pc);
                    chk("dec_instr", dec_instr, exp_i);
                    chk("dec_opcode", {25'b0, dec_opcode}, {25'b0, exp_i[6:0]});
                    m_dec_pc = m_dec_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] target;
        rst = 1'b1;
        dec_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_lat = 1;
        mem_stall = 1'b0;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("reset_req_addr", imem_req_addr, 32'h0);
        chk("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("reset_dec_instr", dec_instr, 32'h0);
        chk("reset_dec_pc", dec_pc, 32'h0);
        chk("reset_dec_opcode", {25'b0, dec_opcode}, 32'h0);

        // Zero-wait stream
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t1_req0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req0_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t1_req1_addr", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("t1_dec0_valid", {31'b0, dec_valid}, 32'd1);
        chk("t1_dec0_pc", dec_pc, 32'h0);
        chk("t1_dec0_instr", dec_instr, 32'h055E_6F03);
        chk("t1_dec0_opcode", {25'b0, dec_opcode}, 32'h03);
        @(negedge clk);
        chk("t1_dec1_valid", {31'b0, dec_valid}, 32'd1);
        chk("t1_dec1_pc", dec_pc, 32'h4);
        chk("t1_dec1_instr", dec_instr, 32'h055E_6FA3);
        wait_dec(32'h20, 40);

        // Decode stalled: exactly DEPTH requests, then nothing lost
        step(); rst = 1'b1;
        step(); rst = 1'b0; dec_ready = 1'b0; base = acc_cnt;
        repeat (8) @(negedge clk);
        chk("t2_accepts", acc_cnt - base, 32'd2);
        chk("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("t2_head_pc", dec_pc, 32'h0);
        step(); dec_ready = 1'b1;
        wait_dec(32'h10, 40);

        // Redirect with two in flight on a 3-cycle memory
        step(); rst = 1'b1; mem_lat = 3;
        step(); rst = 1'b0;
        @(negedge clk);
        step();
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_flush_req_a", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_flush_dec_a", {31'b0, dec_valid}, 32'd0);
        @(negedge clk);
        chk("t3_flush_req_b", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_flush_dec_b", {31'b0, dec_valid}, 32'd0);
        @(negedge clk);
        chk("t3_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t3_resume_addr", imem_req_addr, 32'h100);
        wait_dec(32'h100, 40);

        // Redirect coincident with a response and a decode handshake
        step(); rst = 1'b1; mem_lat = 1;
        step(); rst = 1'b0;
        @(negedge clk);
        step();
        step(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("t4_dec_valid", {31'b0, dec_valid}, 32'd0);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_next_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t4_next_addr", imem_req_addr, 32'h100);
        chk("t4_queue_flushed", {31'b0, dec_valid}, 32'd0);
        wait_dec(32'h100, 40);

        // Unaligned redirect target
        step(); dec_ready = 1'b0;
        repeat (8) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_align_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_align_addr", imem_req_addr, 32'h200);
        step(); dec_ready = 1'b1;
        wait_dec(32'h208, 40);

        // PC wrap at the top of the address space
        step(); dec_ready = 1'b0;
        repeat (8) step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_wrap_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);
        step(); dec_ready = 1'b1;
        wait_dec(32'h4, 40);

        // Reset mid-stream with a full queue
        step(); dec_ready = 1'b0;
        repeat (8) step();
        @(negedge clk);
        chk("t6_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("t6_dec_instr", dec_instr, 32'h0);
        chk("t6_req_addr", imem_req_addr, RESET_PC);
        chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step(); dec_ready = 1'b1;
        wait_dec(32'h8, 40);

        // Mixed traffic: random memory ready, decode stalls and redirects
        step(); mem_lat = 2; mem_stall = 1'b1;
        for (int i = 0; i < 400; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom_range(0, 32'h3FF);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0; dec_ready = 1'b1; mem_stall = 1'b0;
        target = m_dec_pc + 32'd8;
        wait_dec(target, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
